// File: rtl/regacc_pkg.sv
// rtl/regacc_pkg.sv - shared types and widths for the register-access master
package regacc_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } regacc_state_t;

endpackage

// File: rtl/regacc_timeout_ctr.sv
// rtl/regacc_timeout_ctr.sv - saturating WAIT-state cycle counter with limit flag
module regacc_timeout_ctr #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(LIMIT));

endmodule

// File: rtl/reg_access_master.sv
// rtl/reg_access_master.sv - one-at-a-time register file access initiator; REGACC_TIMEOUT_EN adds a WAIT timeout
module reg_access_master
    import regacc_pkg::*;
#(
    parameter int DATA_W         = REG_DATA_W,
    parameter int ADDR_W         = REG_ADDR_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs,
    input  logic [ADDR_W-1:0] req_rt,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic              req_wr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata1,
    output logic [DATA_W-1:0] resp_rdata2,
    output logic              resp_err,
    output logic              busy,
    output logic              rf_en,
    output logic              rf_reg_write,
    output logic [ADDR_W-1:0] rf_read_reg1,
    output logic [ADDR_W-1:0] rf_read_reg2,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    input  logic              rf_register_done
);

    regacc_state_t state, state_next;
    logic          lat_wr;
    logic          accept;
    logic          capture;
    logic          timed_out;

    assign accept  = (state == IDLE) && req_valid;
    assign capture = (state == WAIT) && rf_register_done;

`ifdef REGACC_TIMEOUT_EN
    logic expired;
    logic err_q;

    regacc_timeout_ctr #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == ISSUE),
        .inc    (state == WAIT),
        .expired(expired)
    );

    // A done arriving on the limit cycle wins over the timeout.
    assign timed_out = (state == WAIT) && !rf_register_done && expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (capture) begin
            err_q <= 1'b0;
        end else if (timed_out) begin
            err_q <= 1'b1;
        end
    end

    assign resp_err = err_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timed_out = 1'b0;
    assign resp_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (capture || timed_out) state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request fields double as the rf_* drive and hold until the next acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_read_reg1  <= '0;
            rf_read_reg2  <= '0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
            lat_wr        <= 1'b0;
        end else if (accept) begin
            rf_read_reg1  <= req_rs;
            rf_read_reg2  <= req_rt;
            rf_write_reg  <= req_rd;
            rf_write_data <= req_wdata;
            lat_wr        <= req_wr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_rdata1 <= '0;
            resp_rdata2 <= '0;
        end else if (capture) begin
            resp_rdata1 <= rf_read_data1;
            resp_rdata2 <= rf_read_data2;
        end else if (timed_out) begin
            resp_rdata1 <= '0;
            resp_rdata2 <= '0;
        end
    end

    assign req_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign rf_en        = (state == ISSUE);
    assign rf_reg_write = (state == ISSUE) && lat_wr;
    assign resp_valid   = (state == RESP);

endmodule

// File: tb/tb_reg_access_master.sv
// tb/tb_reg_access_master.sv - self-checking bench for reg_access_master
module tb_reg_access_master;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_rs = '0, req_rt = '0, req_rd = '0;
    logic          req_wr = 1'b0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_rdata1, resp_rdata2;
    logic          resp_err, busy, rf_en, rf_reg_write;
    logic [AW-1:0] rf_read_reg1, rf_read_reg2, rf_write_reg;
    logic [DW-1:0] rf_write_data;
    logic [DW-1:0] rf_read_data1 = '0, rf_read_data2 = '0;
    logic          rf_register_done;

    always #5 clk = ~clk;

    reg_access_master #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_wr(req_wr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata1(resp_rdata1), .resp_rdata2(resp_rdata2), .resp_err(resp_err),
        .busy(busy), .rf_en(rf_en), .rf_reg_write(rf_reg_write),
        .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
        .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .rf_register_done(rf_register_done)
    );

    // Register file model: samples on enable, read-before-write, x0 hardwired.
    logic [DW-1:0] rf_regs [32] = '{3: 32'h1111_1111, 4: 32'h2222_2222, default: 32'h0};
    logic          done_auto = 1'b0;
    logic          done_inject = 1'b0;
    logic          block_done = 1'b0;
    int            en_count = 0;
    int            wr_count = 0;

    assign rf_register_done = done_auto | done_inject;

    always @(posedge clk) begin
        done_auto <= 1'b0;
        if (rf_en) begin
            en_count      <= en_count + 1;
            rf_read_data1 <= rf_regs[rf_read_reg1];
            rf_read_data2 <= rf_regs[rf_read_reg2];
            if (rf_reg_write) begin
                wr_count <= wr_count + 1;
                if (rf_write_reg != 0) rf_regs[rf_write_reg] <= rf_write_data;
            end
            done_auto <= !block_done;
        end
    end

    // Request-level reference: each access returns the pre-write pair, then commits.
    logic [DW-1:0] ref_regs [32] = '{3: 32'h1111_1111, 4: 32'h2222_2222, default: 32'h0};

    task automatic ref_access(input logic [AW-1:0] rs, rt, rd, input logic wr,
                              input logic [DW-1:0] wd, output logic [DW-1:0] e1, e2);
        e1 = ref_regs[rs];
        e2 = ref_regs[rt];
        if (wr && rd != 0) ref_regs[rd] = wd;
    endtask

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_req(input logic [AW-1:0] rs, rt, rd, input logic wr,
                           input logic [DW-1:0] wd, input int hold,
                           output logic [DW-1:0] d1, d2, output logic e, output int lat);
        int en0;
        int wr0;
        chk("req_ready_idle", {31'b0, req_ready}, 1);
        en0 = en_count;
        wr0 = wr_count;
        req_rs = rs; req_rt = rt; req_rd = rd; req_wr = wr; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_rs = AW'($urandom); req_rt = AW'($urandom); req_rd = AW'($urandom);
        req_wr = 1'($urandom); req_wdata = $urandom;
        chk("issue_rf_en", {31'b0, rf_en}, 1);
        chk("issue_rf_wr", {31'b0, rf_reg_write}, {31'b0, wr});
        chk("issue_rs", {27'b0, rf_read_reg1}, {27'b0, rs});
        chk("issue_rt", {27'b0, rf_read_reg2}, {27'b0, rt});
        chk("issue_rd", {27'b0, rf_write_reg}, {27'b0, rd});
        chk("issue_wdata", rf_write_data, wd);
        lat = 0;
        while (!resp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("resp_arrived", {31'b0, resp_valid}, 1);
        chk("rf_en_one_cycle", en_count - en0, 1);
        chk("rf_wr_pulses", wr_count - wr0, {31'b0, wr});
        d1 = resp_rdata1; d2 = resp_rdata2; e = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'b0, resp_valid}, 1);
            chk("hold_rdata1", resp_rdata1, d1);
            chk("hold_req_ready", {31'b0, req_ready}, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("back_idle", {30'b0, busy, resp_valid}, 0);
        chk("rf_rs_held", {27'b0, rf_read_reg1}, {27'b0, rs});
    endtask

    typedef struct {
        logic [AW-1:0] rs, rt, rd;
        logic          wr;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp1, exp2;
    } vec_t;

    vec_t          vecs [7];
    logic [DW-1:0] d1, d2, e1, e2;
    logic          er;
    int            lat;

    initial begin
        vecs[0] = '{5'd3, 5'd4, 5'd0, 1'b0, 32'h0,         32'h1111_1111, 32'h2222_2222};
        vecs[1] = '{5'd3, 5'd4, 5'd5, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222};
        vecs[2] = '{5'd5, 5'd3, 5'd0, 1'b0, 32'h0,         32'hDEAD_BEEF, 32'h1111_1111};
        vecs[3] = '{5'd5, 5'd5, 5'd5, 1'b1, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[4] = '{5'd5, 5'd0, 5'd0, 1'b0, 32'h0,         32'hCAFE_F00D, 32'h0};
        vecs[5] = '{5'd0, 5'd0, 5'd0, 1'b1, 32'h1234_5678, 32'h0,         32'h0};
        vecs[6] = '{5'd0, 5'd5, 5'd0, 1'b0, 32'h0,         32'h0,         32'hCAFE_F00D};

        #3;
        chk("rst_ready", {31'b0, req_ready}, 1);
        chk("rst_ctrl", {27'b0, rf_en, rf_reg_write, resp_valid, resp_err, busy}, 0);
        chk("rst_rdata1", resp_rdata1, 0);
        chk("rst_rf_idx", {17'b0, rf_read_reg1, rf_read_reg2, rf_write_reg}, 0);
        chk("rst_wdata", rf_write_data, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_req(vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].wr, vecs[i].wd, 0, d1, d2, er, lat);
            ref_access(vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].wr, vecs[i].wd, e1, e2);
            chk($sformatf("vec%0d_rdata1", i), d1, vecs[i].exp1);
            chk($sformatf("vec%0d_rdata2", i), d2, vecs[i].exp2);
            chk($sformatf("vec%0d_err", i), {31'b0, er}, 0);
            chk($sformatf("vec%0d_latency", i), lat, 2);
        end

        // Backpressure with a competing request that must not be taken.
        req_rs = 5'd3; req_rt = 5'd5; req_rd = 5'd0; req_wr = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_rs = 5'd4; req_wr = 1'b1; req_rd = 5'd7; req_wdata = 32'h0BAD_0BAD;
        while (!resp_valid) begin @(posedge clk); #1; end
        ref_access(5'd3, 5'd5, 5'd0, 1'b0, 32'h0, e1, e2);
        lat = en_count;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'b0, resp_valid}, 1);
            chk("bp_rdata1", resp_rdata1, e1);
            chk("bp_rdata2", resp_rdata2, e2);
            chk("bp_req_ready", {31'b0, req_ready}, 0);
        end
        chk("bp_no_accept", en_count - lat, 0);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("bp_released", {31'b0, req_ready}, 1);

        // Spurious done in IDLE and in ISSUE; only a done in WAIT completes.
        done_inject = 1'b1;
        @(posedge clk); #1;
        done_inject = 1'b0;
        chk("spur_idle", {30'b0, busy, resp_valid}, 0);
        block_done = 1'b1;
        req_rs = 5'd4; req_rt = 5'd3; req_wr = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        done_inject = 1'b1;
        @(posedge clk); #1;
        done_inject = 1'b0;
        chk("spur_issue", {31'b0, resp_valid}, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("wait_no_done", {30'b0, resp_valid, busy}, 1);
        end
        done_inject = 1'b1;
        @(posedge clk); #1;
        done_inject = 1'b0;
        block_done = 1'b0;
        ref_access(5'd4, 5'd3, 5'd0, 1'b0, 32'h0, e1, e2);
        chk("real_done_valid", {31'b0, resp_valid}, 1);
        chk("real_done_rdata1", resp_rdata1, e1);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;

        // Asynchronous reset during WAIT.
        req_rs = 5'd4; req_rt = 5'd4; req_rd = 5'd9; req_wr = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_busy", {31'b0, busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctrl", {27'b0, rf_en, rf_reg_write, resp_valid, resp_err, busy}, 0);
        chk("arst_idx", {17'b0, rf_read_reg1, rf_read_reg2, rf_write_reg}, 0);
        chk("arst_rdata", resp_rdata1 | resp_rdata2, 0);
        chk("arst_ready", {31'b0, req_ready}, 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_req(5'd5, 5'd3, 5'd0, 1'b0, 32'h0, 0, d1, d2, er, lat);
        ref_access(5'd5, 5'd3, 5'd0, 1'b0, 32'h0, e1, e2);
        chk("post_rst_rdata1", d1, e1);
        chk("post_rst_rdata2", d2, e2);

        // Randomized traffic against the request-level reference.
        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] rs, rt, rd;
            logic          wr;
            logic [DW-1:0] wd;
            rs = AW'($urandom); rt = AW'($urandom); rd = AW'($urandom);
            wr = 1'($urandom); wd = $urandom;
            run_req(rs, rt, rd, wr, wd, int'($urandom_range(0, 3)), d1, d2, er, lat);
            ref_access(rs, rt, rd, wr, wd, e1, e2);
            chk("rand_rdata1", d1, e1);
            chk("rand_rdata2", d2, e2);
            chk("rand_err", {31'b0, er}, 0);
            chk("rand_latency", lat, 2);
        end

`ifdef REGACC_TIMEOUT_EN
        block_done = 1'b1;
        run_req(5'd3, 5'd4, 5'd0, 1'b0, 32'h0, 0, d1, d2, er, lat);
        ref_access(5'd3, 5'd4, 5'd0, 1'b0, 32'h0, e1, e2);
        chk("to_err", {31'b0, er}, 1);
        chk("to_rdata", d1 | d2, 0);
        chk("to_latency", lat, TO + 2);
        req_rs = 5'd3; req_rt = 5'd4; req_wr = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < TO + 1; i++) begin @(posedge clk); #1; end
        chk("to_limit_pending", {31'b0, resp_valid}, 0);
        done_inject = 1'b1;
        @(posedge clk); #1;
        done_inject = 1'b0;
        block_done = 1'b0;
        ref_access(5'd3, 5'd4, 5'd0, 1'b0, 32'h0, e1, e2);
        chk("to_limit_valid", {31'b0, resp_valid}, 1);
        chk("to_limit_err", {31'b0, resp_err}, 0);
        chk("to_limit_rdata1", resp_rdata1, e1);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
